// File: rtl/uart_rx_frame_if.sv
// Serial-line and capture-memory write signals of the framed UART receiver.
// The receiver takes the master view; the line driver / memory side takes the slave view.
interface uart_rx_frame_if #(
   parameter int DATA_BITS = 8,
   parameter int ADDR_W    = 8
);
   logic                 Rx_in;
   logic [DATA_BITS-1:0] data_out;
   logic                 wr;
   logic [ADDR_W-1:0]    wr_addr;
   logic                 frame_done;
   logic                 parity_err;
   logic                 frame_err;
   logic                 busy;

   modport master (
      input  Rx_in,
      output data_out, wr, wr_addr, frame_done, parity_err, frame_err, busy
   );

   modport slave (
      output Rx_in,
      input  data_out, wr, wr_addr, frame_done, parity_err, frame_err, busy
   );
endinterface

// File: rtl/uart_rx_frame.sv
// Oversampled UART receiver with optional parity, stop-bit check, frame address counter
// and inter-character gap timeout, writing each good character into a capture memory.
module uart_rx_frame #(
   parameter int FCLK      = 100_000_000,
   parameter int BAUD      = 115200,
   parameter int OVS       = 16,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int FRAME_LEN = 113,
   parameter int ADDR_W    = 8,
   parameter int IDLE_TO   = 32
) (
   input  logic            clk_Rx,
   input  logic            rst_n,
   uart_rx_frame_if.master bus
);
   localparam longint DIV_L = (longint'(FCLK) + (longint'(BAUD) * OVS) / 2) / (longint'(BAUD) * OVS);
   localparam int DIV       = (DIV_L < 1) ? 1 : int'(DIV_L);
   localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TICK_W    = $clog2(OVS);
   localparam int BIT_W     = $clog2(DATA_BITS);
   localparam int GAP_TICKS = IDLE_TO * OVS;
   localparam int GAP_W     = $clog2(GAP_TICKS + 2);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, RECOVER} state_t;

   state_t               state;
   logic                 rx_meta, rxs, rxs_q;
   logic [DIV_W-1:0]     div_cnt;
   logic                 tick;
   logic [TICK_W-1:0]    tick_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic [GAP_W-1:0]     gap_cnt;
   logic                 gap_hit;
   logic [DATA_BITS-1:0] data_r;
   logic                 wr_r, fd_r, pe_r, fe_r, busy_r;
   logic [ADDR_W-1:0]    addr_r;

   function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
      logic x;
      x = ^{d, p};
      if (PARITY == 1) return ~x;
      else if (PARITY == 2) return x;
      else return 1'b0;
   endfunction

   // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle level is high
   always_ff @(posedge clk_Rx or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
         rxs_q   <= 1'b1;
      end else begin
         rx_meta <= bus.Rx_in;
         rxs     <= rx_meta;
         rxs_q   <= rxs;
      end
   end

   assign tick = (div_cnt == DIV_W'(DIV - 1));

   always_ff @(posedge clk_Rx or negedge rst_n) begin
      if (!rst_n) div_cnt <= '0;
      else        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
   end

   // Gap timer only runs while a frame is open and the line is quiet
   assign gap_hit = (GAP_TICKS != 0) && (state == IDLE) && (addr_r != '0) && !wr_r
                    && (gap_cnt == GAP_W'(GAP_TICKS));

   always_ff @(posedge clk_Rx or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         gap_cnt  <= '0;
         data_r   <= '0;
         wr_r     <= 1'b0;
         addr_r   <= '0;
         fd_r     <= 1'b0;
         pe_r     <= 1'b0;
         fe_r     <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         wr_r <= 1'b0;
         fd_r <= 1'b0;
         pe_r <= 1'b0;
         fe_r <= 1'b0;

         if (wr_r) begin
            if (addr_r == LAST_ADDR) begin
               addr_r <= '0;
               fd_r   <= 1'b1;
            end else begin
               addr_r <= addr_r + ADDR_W'(1);
            end
         end

         if (GAP_TICKS == 0 || gap_hit || state != IDLE || addr_r == '0 || wr_r)
            gap_cnt <= '0;
         else if (tick)
            gap_cnt <= gap_cnt + GAP_W'(1);

         case (state)
            IDLE: begin
               if (gap_hit) begin
                  fe_r   <= 1'b1;
                  addr_r <= '0;
               end
               if (rxs_q && !rxs) begin
                  state    <= START;
                  busy_r   <= 1'b1;
                  tick_cnt <= '0;
               end
            end
            START: if (tick) begin
               if (tick_cnt == TICK_W'(OVS / 2 - 1)) begin
                  tick_cnt <= '0;
                  if (rxs) begin
                     state  <= IDLE;
                     busy_r <= 1'b0;
                  end else begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end else begin
                  tick_cnt <= tick_cnt + TICK_W'(1);
               end
            end
            DATA: if (tick) begin
               if (tick_cnt == TICK_W'(OVS - 1)) begin
                  tick_cnt <= '0;
                  shreg    <= {rxs, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == BIT_W'(DATA_BITS - 1)) state <= (PARITY != 0) ? PAR : STOP;
                  else bit_cnt <= bit_cnt + BIT_W'(1);
               end else begin
                  tick_cnt <= tick_cnt + TICK_W'(1);
               end
            end
            PAR: if (tick) begin
               if (tick_cnt == TICK_W'(OVS - 1)) begin
                  tick_cnt <= '0;
                  par_bit  <= rxs;
                  state    <= STOP;
               end else begin
                  tick_cnt <= tick_cnt + TICK_W'(1);
               end
            end
            STOP: if (tick) begin
               if (tick_cnt == TICK_W'(OVS - 1)) begin
                  tick_cnt <= '0;
                  // A low stop bit outranks a parity error and leaves us waiting for the line to rise
                  if (!rxs) begin
                     fe_r  <= 1'b1;
                     state <= RECOVER;
                  end else if (parity_bad(shreg, par_bit)) begin
                     pe_r   <= 1'b1;
                     state  <= IDLE;
                     busy_r <= 1'b0;
                  end else begin
                     data_r <= shreg;
                     wr_r   <= 1'b1;
                     state  <= IDLE;
                     busy_r <= 1'b0;
                  end
               end else begin
                  tick_cnt <= tick_cnt + TICK_W'(1);
               end
            end
            RECOVER: if (rxs) begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_out   = data_r;
   assign bus.wr         = wr_r;
   assign bus.wr_addr    = addr_r;
   assign bus.frame_done = fd_r;
   assign bus.parity_err = pe_r;
   assign bus.frame_err  = fe_r;
   assign bus.busy       = busy_r;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 receiver (timeout 4 bit times) and an 8E1 receiver, both FRAME_LEN=4.
module tb_uart_rx_frame;
   logic clk;
   logic rst_n;

   uart_rx_frame_if #(.DATA_BITS(8), .ADDR_W(8)) ia();
   uart_rx_frame_if #(.DATA_BITS(8), .ADDR_W(8)) ib();

   uart_rx_frame #(.FCLK(1_843_200), .BAUD(115200), .OVS(16), .DATA_BITS(8), .PARITY(0),
                   .FRAME_LEN(4), .ADDR_W(8), .IDLE_TO(4))
      dut_a (.clk_Rx(clk), .rst_n(rst_n), .bus(ia));

   uart_rx_frame #(.FCLK(1_843_200), .BAUD(115200), .OVS(16), .DATA_BITS(8), .PARITY(2),
                   .FRAME_LEN(4), .ADDR_W(8), .IDLE_TO(0))
      dut_b (.clk_Rx(clk), .rst_n(rst_n), .bus(ib));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   int         n_wr[2], n_pe[2], n_fe[2], n_fd[2];
   logic [7:0] last_data[2];
   int         last_addr[2];
   logic       pw[2];
   int         pa[2];
   int         maddr[2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Event monitor, sampled on the falling edge
   initial begin
      for (int k = 0; k < 2; k++) begin
         n_wr[k] = 0; n_pe[k] = 0; n_fe[k] = 0; n_fd[k] = 0;
         last_data[k] = '0; last_addr[k] = 0; pw[k] = 1'b0; pa[k] = 0;
      end
   end

   always @(negedge clk) begin
      if (ia.wr) begin
         n_wr[0]++; last_data[0] = ia.data_out; last_addr[0] = int'(ia.wr_addr);
         check("wr_single_cycle_a", 64'(pw[0]), 64'd0);
      end
      if (pw[0] && rst_n) begin
         check("addr_after_wr_a", 64'(ia.wr_addr), 64'((pa[0] + 1) % 4));
         check("frame_done_after_wr_a", 64'(ia.frame_done), 64'(pa[0] == 3));
      end
      if (ia.frame_done) n_fd[0]++;
      if (ia.parity_err) n_pe[0]++;
      if (ia.frame_err)  n_fe[0]++;
      pw[0] = ia.wr; pa[0] = int'(ia.wr_addr);

      if (ib.wr) begin
         n_wr[1]++; last_data[1] = ib.data_out; last_addr[1] = int'(ib.wr_addr);
         check("wr_single_cycle_b", 64'(pw[1]), 64'd0);
      end
      if (pw[1] && rst_n) begin
         check("addr_after_wr_b", 64'(ib.wr_addr), 64'((pa[1] + 1) % 4));
         check("frame_done_after_wr_b", 64'(ib.frame_done), 64'(pa[1] == 3));
      end
      if (ib.frame_done) n_fd[1]++;
      if (ib.parity_err) n_pe[1]++;
      if (ib.frame_err)  n_fe[1]++;
      pw[1] = ib.wr; pa[1] = int'(ib.wr_addr);
   end

   task automatic hold(input int w, input logic v, input int clocks);
      if (w == 0) ia.Rx_in = v;
      else        ib.Rx_in = v;
      repeat (clocks) @(posedge clk);
      #1;
   endtask

   // One bit lasts OVS*DIV = 16 clocks; only dut_b carries a parity bit
   task automatic send(input int w, input logic [7:0] d, input logic p, input logic stop, input int gap);
      hold(w, 1'b0, 16);
      for (int i = 0; i < 8; i++) hold(w, d[i], 16);
      if (w == 1) hold(w, p, 16);
      hold(w, stop, 16);
      if (gap > 0) hold(w, 1'b1, 16 * gap);
   endtask

   task automatic run_char(input string tag, input int w, input logic [7:0] d, input logic p,
                           input logic stop, input int gap, input int ewr, input int epe,
                           input int efe, input int efd, input int eaddr);
      int wr0, pe0, fe0, fd0;
      wr0 = n_wr[w]; pe0 = n_pe[w]; fe0 = n_fe[w]; fd0 = n_fd[w];
      send(w, d, p, stop, gap);
      check({tag, " wr/pe/fe/fd counts"},
            64'({8'(n_wr[w] - wr0), 8'(n_pe[w] - pe0), 8'(n_fe[w] - fe0), 8'(n_fd[w] - fd0)}),
            64'({8'(ewr), 8'(epe), 8'(efe), 8'(efd)}));
      if (ewr == 1) begin
         check({tag, " data"}, 64'(last_data[w]), 64'(d));
         check({tag, " addr"}, 64'(last_addr[w]), 64'(eaddr));
      end
   endtask

   function automatic logic [63:0] outs(input int w);
      if (w == 0) return 64'({ia.data_out, ia.wr, ia.wr_addr, ia.frame_done, ia.parity_err, ia.frame_err, ia.busy});
      return 64'({ib.data_out, ib.wr, ib.wr_addr, ib.frame_done, ib.parity_err, ib.frame_err, ib.busy});
   endfunction

   typedef struct {
      int         w;
      logic [7:0] d;
      logic       p;
      logic       stop;
      int         ewr, epe, efe, efd, eaddr;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected normal end");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr0, pe0, fe0, fd0;
      int gaps[4];
      tbl[0]  = '{0, 8'h01, 1'b0, 1'b1, 1, 0, 0, 0, 0};
      tbl[1]  = '{0, 8'h02, 1'b0, 1'b1, 1, 0, 0, 0, 1};
      tbl[2]  = '{0, 8'h03, 1'b0, 1'b1, 1, 0, 0, 0, 2};
      tbl[3]  = '{0, 8'h04, 1'b0, 1'b1, 1, 0, 0, 1, 3};
      tbl[4]  = '{1, 8'h03, 1'b0, 1'b1, 1, 0, 0, 0, 0};
      tbl[5]  = '{1, 8'h03, 1'b1, 1'b1, 0, 1, 0, 0, 0};
      tbl[6]  = '{1, 8'h80, 1'b1, 1'b1, 1, 0, 0, 0, 1};
      tbl[7]  = '{1, 8'h80, 1'b0, 1'b1, 0, 1, 0, 0, 0};
      tbl[8]  = '{1, 8'h5A, 1'b0, 1'b0, 0, 0, 1, 0, 0};
      tbl[9]  = '{0, 8'h3C, 1'b0, 1'b0, 0, 0, 1, 0, 0};
      tbl[10] = '{1, 8'h7E, 1'b0, 1'b1, 1, 0, 0, 0, 2};
      gaps = '{0, 1, 2, 6};

      rst_n = 1'b0;
      ia.Rx_in = 1'b1;
      ib.Rx_in = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("reset_outputs_a", outs(0), 64'd0);
      check("reset_outputs_b", outs(1), 64'd0);
      rst_n = 1'b1;
      hold(0, 1'b1, 40);

      // 8N1 0xA5 lands at address 0, then the address moves to 1
      run_char("a5", 0, 8'hA5, 1'b0, 1'b1, 1, 1, 0, 0, 0, 0);
      check("a5 data_out", 64'(ia.data_out), 64'hA5);
      check("a5 wr_addr_next", 64'(ia.wr_addr), 64'd1);

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      maddr[0] = 0; maddr[1] = 0;
      hold(0, 1'b1, 20);

      for (int i = 0; i < 11; i++)
         run_char($sformatf("tbl%0d", i), tbl[i].w, tbl[i].d, tbl[i].p, tbl[i].stop, 1,
                  tbl[i].ewr, tbl[i].epe, tbl[i].efe, tbl[i].efd, tbl[i].eaddr);
      check("frame wrap wr_addr_a", 64'(ia.wr_addr), 64'd0);
      check("parity drop wr_addr_b", 64'(ib.wr_addr), 64'd3);
      maddr[0] = 0; maddr[1] = 3;

      // Break: bad stop bit then line held low 20 bit times -> one frame_err, busy until line rises
      fe0 = n_fe[0]; wr0 = n_wr[0];
      send(0, 8'h55, 1'b0, 1'b0, 0);
      hold(0, 1'b0, 20 * 16);
      check("break busy", 64'(ia.busy), 64'd1);
      check("break single frame_err", 64'(n_fe[0] - fe0), 64'd1);
      hold(0, 1'b1, 8);
      check("break released busy", 64'(ia.busy), 64'd0);
      check("break no wr", 64'(n_wr[0] - wr0), 64'd0);
      run_char("after_break", 0, 8'h3C, 1'b0, 1'b1, 1, 1, 0, 0, 0, 0);

      // Gap timeout: two more characters then a 5-bit idle closes the frame
      run_char("to_1", 0, 8'h11, 1'b0, 1'b1, 1, 1, 0, 0, 0, 1);
      run_char("to_2", 0, 8'h22, 1'b0, 1'b1, 5, 1, 0, 1, 0, 2);
      check("timeout wr_addr", 64'(ia.wr_addr), 64'd0);
      maddr[0] = 0;

      // Glitch: 3 clocks low is rejected at the start-bit centre
      wr0 = n_wr[0]; pe0 = n_pe[0]; fe0 = n_fe[0]; fd0 = n_fd[0];
      hold(0, 1'b0, 3);
      hold(0, 1'b1, 24);
      check("glitch busy", 64'(ia.busy), 64'd0);
      check("glitch no events",
            64'({8'(n_wr[0] - wr0), 8'(n_pe[0] - pe0), 8'(n_fe[0] - fe0), 8'(n_fd[0] - fd0)}), 64'd0);

      // Randomised characters against the frame-level model
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            logic       stop, p;
            int         gap, ewr, epe, efe, efd, ea;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            p    = (^d) ^ ($urandom_range(0, 3) == 0);
            gap  = stop ? gaps[$urandom_range(0, 3)] : gaps[$urandom_range(1, 3)];
            ewr = 0; epe = 0; efe = 0; efd = 0; ea = maddr[w];
            if (!stop) efe = 1;
            else if (w == 1 && p != ^d) epe = 1;
            else begin
               ewr = 1;
               efd = (maddr[w] == 3) ? 1 : 0;
               maddr[w] = (maddr[w] + 1) % 4;
            end
            if (w == 0 && gap >= 5 && maddr[0] != 0) begin
               efe++;
               maddr[0] = 0;
            end
            run_char($sformatf("rnd%0d_%0d", w, i), w, d, p, stop, gap, ewr, epe, efe, efd, ea);
         end
         hold(w, 1'b1, 16);
      end

      // Reset mid-character: outputs clear immediately and nothing is written
      hold(0, 1'b1, 16 * 6);
      wr0 = n_wr[0];
      hold(0, 1'b0, 16);
      hold(0, 1'b1, 16);
      hold(0, 1'b0, 16);
      check("pre_reset busy", 64'(ia.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_char reset outputs_a", outs(0), 64'd0);
      check("mid_char reset outputs_b", outs(1), 64'd0);
      hold(0, 1'b1, 4);
      rst_n = 1'b1;
      hold(0, 1'b1, 200);
      check("mid_char reset no wr", 64'(n_wr[0] - wr0), 64'd0);
      check("post_reset idle", outs(0), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
